// File: rtl/ram_rd_fwd_pkg.sv
// Shared types and helpers for the multi-port SRAM read-data forwarding block.
// RAM_RD_FWD_STAGE_T builds a stage record for arbitrary address/data widths.
package ram_rd_fwd_pkg;

  localparam int unsigned MAX_RD_LATENCY = 8;
  localparam int unsigned MAX_DATA_WIDTH = 64;

  // Default-width stage record; modules with other widths use the macro below
  localparam int unsigned FWD_ADDR_WIDTH = 4;
  localparam int unsigned FWD_DATA_WIDTH = 8;

  typedef struct packed {
    logic                      vld;
    logic [FWD_ADDR_WIDTH-1:0] addr;
    logic [FWD_DATA_WIDTH-1:0] mask;
    logic [FWD_DATA_WIDTH-1:0] data;
  } fwd_stage_t;

  // Accumulated forwarding state, zero-extended to the widest supported data
  typedef struct packed {
    logic [MAX_DATA_WIDTH-1:0] mask;
    logic [MAX_DATA_WIDTH-1:0] data;
  } merge_t;

  // Overlay one masked write onto accumulated forwarding state
  function automatic merge_t merge_bits(input logic [MAX_DATA_WIDTH-1:0] data,
                                        input logic [MAX_DATA_WIDTH-1:0] mask,
                                        input logic [MAX_DATA_WIDTH-1:0] wdata,
                                        input logic [MAX_DATA_WIDTH-1:0] wmask);
    merge_t r;
    r.mask = mask | wmask;
    r.data = (data & ~wmask) | (wdata & wmask);
    return r;
  endfunction

endpackage

`define RAM_RD_FWD_STAGE_T(aw, dw) struct packed { logic vld; logic [(aw)-1:0] addr; logic [(dw)-1:0] mask; logic [(dw)-1:0] data; }

// File: rtl/ram_rd_fwd_merge.sv
// Combinational merge of all write ports into one forwarding stage.
// Ports are applied in ascending index so the higher port wins per bit.
module ram_rd_fwd_merge
  import ram_rd_fwd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_WR     = 2
) (
  input  logic                         vld,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]        mask_in,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_mask,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0]        mask_out_c,
  output logic [DATA_WIDTH-1:0]        data_out_c
);

  merge_t acc;

  // Fold every hitting write port into the stage, lowest index first
  always_comb begin
    acc.mask = MAX_DATA_WIDTH'(mask_in);
    acc.data = MAX_DATA_WIDTH'(data_in);
    for (int p = 0; p < int'(NUM_WR); p++) begin
      if (vld && wr_en[p] && (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == addr)) begin
        acc = merge_bits(acc.data, acc.mask,
                         MAX_DATA_WIDTH'(wr_data[p*DATA_WIDTH +: DATA_WIDTH]),
                         MAX_DATA_WIDTH'(wr_mask[p*DATA_WIDTH +: DATA_WIDTH]));
      end
    end
    mask_out_c = DATA_WIDTH'(acc.mask);
    data_out_c = DATA_WIDTH'(acc.data);
  end

endmodule

// File: rtl/ram_rd_fwd_mp.sv
// Read-data forwarding for a pipelined SRAM with NUM_WR write ports.
// Each read in flight accumulates masked write data hitting its address and the
// result is overlaid on ram_rdata at return time, adding no latency.
// RD_LATENCY legal range 1..MAX_RD_LATENCY, NUM_WR legal range 1..4.
// Optional RAM_RD_FWD_STAT_EN adds saturating read/forward counters.
module ram_rd_fwd_mp
  import ram_rd_fwd_pkg::*;
#(
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_WR       = 2,
  parameter int unsigned RAM_WR_FIRST = 0
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef RAM_RD_FWD_STAT_EN
  input  logic                         stat_clr,
  output logic [15:0]                  fwd_cnt,
  output logic [15:0]                  rd_cnt,
`endif
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_mask,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [DATA_WIDTH-1:0]        ram_rdata,
  output logic                         rd_vld,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         fwd_hit
);

  typedef `RAM_RD_FWD_STAGE_T(ADDR_WIDTH, DATA_WIDTH) stage_t;

  stage_t st_q [RD_LATENCY];
  stage_t st_d [RD_LATENCY];

  // Merge sources: index 0..RD_LATENCY-1 feed the stage registers,
  // index RD_LATENCY is the unregistered output cycle
  logic                  src_vld  [RD_LATENCY+1];
  logic [ADDR_WIDTH-1:0] src_addr [RD_LATENCY+1];
  logic [DATA_WIDTH-1:0] src_mask [RD_LATENCY+1];
  logic [DATA_WIDTH-1:0] src_data [RD_LATENCY+1];
  logic [DATA_WIDTH-1:0] m_mask   [RD_LATENCY+1];
  logic [DATA_WIDTH-1:0] m_data   [RD_LATENCY+1];

  // A write-first RAM already returns the issue-cycle write, so skip it here
  logic [NUM_WR-1:0] wr_en_s0;
  assign wr_en_s0 = (RAM_WR_FIRST != 0) ? '0 : wr_en;

  // Select each merge input: new read for stage 0, previous stage otherwise
  always_comb begin
    for (int s = 0; s <= int'(RD_LATENCY); s++) begin
      if (s == 0) begin
        src_vld[s]  = rd_en;
        src_addr[s] = rd_addr;
        src_mask[s] = '0;
        src_data[s] = '0;
      end else begin
        src_vld[s]  = st_q[s-1].vld;
        src_addr[s] = st_q[s-1].addr;
        src_mask[s] = st_q[s-1].mask;
        src_data[s] = st_q[s-1].data;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g <= int'(RD_LATENCY); g++) begin : g_merge
      ram_rd_fwd_merge #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WR     (NUM_WR)
      ) u_merge (
        .vld        (src_vld[g]),
        .addr       (src_addr[g]),
        .mask_in    (src_mask[g]),
        .data_in    (src_data[g]),
        .wr_en      ((g == 0) ? wr_en_s0 : wr_en),
        .wr_addr    (wr_addr),
        .wr_mask    (wr_mask),
        .wr_data    (wr_data),
        .mask_out_c (m_mask[g]),
        .data_out_c (m_data[g])
      );
    end
  endgenerate

  // Next value of each stage register
  always_comb begin
    for (int s = 0; s < int'(RD_LATENCY); s++) begin
      st_d[s].vld  = src_vld[s];
      st_d[s].addr = src_addr[s];
      st_d[s].mask = m_mask[s];
      st_d[s].data = m_data[s];
    end
  end

  // Advance the read pipeline; reset discards reads in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(RD_LATENCY); s++) begin
        st_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < int'(RD_LATENCY); s++) begin
        st_q[s] <= st_d[s];
      end
    end
  end

  // Overlay forwarded bits on the RAM return in the same cycle
  always_comb begin
    rd_vld  = src_vld[RD_LATENCY];
    rd_data = '0;
    fwd_hit = 1'b0;
    if (rd_vld) begin
      rd_data = (m_mask[RD_LATENCY] & m_data[RD_LATENCY]) |
                (~m_mask[RD_LATENCY] & ram_rdata);
      fwd_hit = |m_mask[RD_LATENCY];
    end
  end

`ifdef RAM_RD_FWD_STAT_EN
  // Saturating read and forward-hit counters; clear beats increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt  <= '0;
      fwd_cnt <= '0;
    end else if (stat_clr) begin
      rd_cnt  <= '0;
      fwd_cnt <= '0;
    end else begin
      if (rd_vld && (rd_cnt != 16'hFFFF)) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
      if (fwd_hit && (fwd_cnt != 16'hFFFF)) begin
        fwd_cnt <= fwd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_rd_fwd_mp.sv
// Directed bench for ram_rd_fwd_mp: one read-first instance and one write-first
// instance share the write/read stimulus. Inputs change on the falling edge and
// outputs are checked 1ns later, well before the next rising edge.
module tb_ram_rd_fwd_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_mask;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [7:0]  ram_rdata;
  logic [7:0]  ram_rdata_wf;
  logic        rd_vld, rd_vld_wf;
  logic [7:0]  rd_data, rd_data_wf;
  logic        fwd_hit, fwd_hit_wf;
`ifdef RAM_RD_FWD_STAT_EN
  logic        stat_clr;
  logic [15:0] fwd_cnt, rd_cnt, fwd_cnt_wf, rd_cnt_wf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_rd_fwd_mp #(.RD_LATENCY(2), .ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_WR(2), .RAM_WR_FIRST(0)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef RAM_RD_FWD_STAT_EN
    .stat_clr  (stat_clr),
    .fwd_cnt   (fwd_cnt),
    .rd_cnt    (rd_cnt),
`endif
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_mask   (wr_mask),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .ram_rdata (ram_rdata),
    .rd_vld    (rd_vld),
    .rd_data   (rd_data),
    .fwd_hit   (fwd_hit)
  );

  ram_rd_fwd_mp #(.RD_LATENCY(2), .ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_WR(2), .RAM_WR_FIRST(1)) dut_wf (
    .clk       (clk),
    .rst       (rst),
`ifdef RAM_RD_FWD_STAT_EN
    .stat_clr  (stat_clr),
    .fwd_cnt   (fwd_cnt_wf),
    .rd_cnt    (rd_cnt_wf),
`endif
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_mask   (wr_mask),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .ram_rdata (ram_rdata_wf),
    .rd_vld    (rd_vld_wf),
    .rd_data   (rd_data_wf),
    .fwd_hit   (fwd_hit_wf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en        = '0;
    wr_addr      = '0;
    wr_mask      = '0;
    wr_data      = '0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    ram_rdata    = '0;
    ram_rdata_wf = '0;
`ifdef RAM_RD_FWD_STAT_EN
    stat_clr     = 1'b0;
`endif
  endtask

  // Start a new cycle with all strobes low
  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input logic [3:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
  endtask

  task automatic wr(input int p, input logic [3:0] a, input logic [7:0] m, input logic [7:0] d);
    wr_en[p]          = 1'b1;
    wr_addr[p*4 +: 4] = a;
    wr_mask[p*8 +: 8] = m;
    wr_data[p*8 +: 8] = d;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rd_vld", 32'(rd_vld), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_fwd_hit", 32'(fwd_hit), 32'd0);
    cyc(); rst = 1'b0;

    // No conflict: plain RAM data passes through
    cyc(); rd(4'd3); #1;
    cyc(); ram_rdata = 8'hFF; #1;
    chk("nc_t1_vld", 32'(rd_vld), 32'd0);
    chk("nc_t1_data_zero", 32'(rd_data), 32'd0);
    cyc(); ram_rdata = 8'hA5; #1;
    chk("nc_vld", 32'(rd_vld), 32'd1);
    chk("nc_data", 32'(rd_data), 32'hA5);
    chk("nc_hit", 32'(fwd_hit), 32'd0);

    // Window edges: issue-cycle write and combinational last-cycle write
    cyc(); rd(4'd5); wr(0, 4'd5, 8'hFF, 8'h11); #1;
    cyc(); #1;
    cyc(); wr(1, 4'd5, 8'h0F, 8'h0C); ram_rdata = 8'h00; ram_rdata_wf = 8'h11; #1;
    chk("edge_vld", 32'(rd_vld), 32'd1);
    chk("edge_data", 32'(rd_data), 32'h1C);
    chk("edge_hit", 32'(fwd_hit), 32'd1);
    chk("edge_wf_data", 32'(rd_data_wf), 32'h1C);
    chk("edge_wf_hit", 32'(fwd_hit_wf), 32'd1);

    // Same-cycle same-bit overlap: port 1 wins
    cyc(); rd(4'd7); #1;
    cyc(); wr(0, 4'd7, 8'hFF, 8'h22); wr(1, 4'd7, 8'hFF, 8'h33); #1;
    cyc(); ram_rdata = 8'h00; #1;
    chk("prio_data", 32'(rd_data), 32'h33);
    chk("prio_wf_data", 32'(rd_data_wf), 32'h33);

    // Partial masks: AA under F0 gives A0, then 55 under 3C gives (A0&C3)|14 = 94
    cyc(); rd(4'd2); wr(0, 4'd2, 8'hF0, 8'hAA); #1;
    cyc(); wr(0, 4'd2, 8'h3C, 8'h55); #1;
    cyc(); ram_rdata = 8'h00; #1;
    chk("partial_data", 32'(rd_data), 32'h94);
    chk("partial_hit", 32'(fwd_hit), 32'd1);
    chk("partial_wf_data", 32'(rd_data_wf), 32'h14);

    // Back-to-back reads to one address; write shares the second read's issue cycle
    cyc(); rd(4'd1); #1;
    cyc(); rd(4'd1); wr(0, 4'd1, 8'hFF, 8'h77); #1;
    cyc(); ram_rdata = 8'h00; ram_rdata_wf = 8'h00; #1;
    chk("b2b_first", 32'(rd_data), 32'h77);
    chk("b2b_wf_first", 32'(rd_data_wf), 32'h77);
    cyc(); ram_rdata = 8'h00; ram_rdata_wf = 8'h5A; #1;
    chk("b2b_second_vld", 32'(rd_vld), 32'd1);
    chk("b2b_second", 32'(rd_data), 32'h77);
    chk("b2b_second_hit", 32'(fwd_hit), 32'd1);
    chk("b2b_wf_second", 32'(rd_data_wf), 32'h5A);
    chk("b2b_wf_second_hit", 32'(fwd_hit_wf), 32'd0);

    // Reset while two reads are in flight: neither returns
    cyc(); rd(4'd4); #1;
    cyc(); rd(4'd4); rst = 1'b1; #1;
    chk("rst_t1_vld", 32'(rd_vld), 32'd0);
    cyc(); rst = 1'b0; ram_rdata = 8'hEE; #1;
    chk("rst_t2_vld", 32'(rd_vld), 32'd0);
    chk("rst_t2_data", 32'(rd_data), 32'd0);
    cyc(); ram_rdata = 8'hEE; #1;
    chk("rst_t3_vld", 32'(rd_vld), 32'd0);
`ifdef RAM_RD_FWD_STAT_EN
    chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("rst_fwd_cnt", 32'(fwd_cnt), 32'd0);
`endif

    // Three reads, only the last is hit by a write in its final cycle
    cyc(); rd(4'd8); #1;
    cyc(); rd(4'd9); #1;
    cyc(); rd(4'd10); ram_rdata = 8'h01; #1;
    chk("stat_r0_data", 32'(rd_data), 32'h01);
    cyc(); ram_rdata = 8'h02; #1;
    chk("stat_r1_hit", 32'(fwd_hit), 32'd0);
    cyc(); wr(1, 4'd10, 8'hFF, 8'h5A); ram_rdata = 8'h03; #1;
    chk("stat_r2_data", 32'(rd_data), 32'h5A);
    chk("stat_r2_hit", 32'(fwd_hit), 32'd1);
    cyc(); #1;
    chk("stat_idle_vld", 32'(rd_vld), 32'd0);
`ifdef RAM_RD_FWD_STAT_EN
    chk("stat_rd_cnt", 32'(rd_cnt), 32'd3);
    chk("stat_fwd_cnt", 32'(fwd_cnt), 32'd1);
    stat_clr = 1'b1;
    cyc(); #1;
    chk("clr_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("clr_fwd_cnt", 32'(fwd_cnt), 32'd0);
`endif

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
